// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port, variable-latency memory between instruction fetch
//   (IF, read-only) and the data-memory stage (DM, load/store). A winning
//   request is latched at grant, the memory handshake is sequenced through
//   IDLE -> BUSY -> RESP, and the result is returned with a one-cycle ack.
//   DM normally wins conflicts, but IF is forced through after MAX_STARVE
//   consecutive conflict losses so fetch can never starve.
//
// Ports
//   clk, reset              clock (rising edge), async active-high reset
//   if_req/if_addr          IF read request, held until if_ack
//   if_ack/if_rdata         one-cycle completion pulse + instruction word
//   dm_req/dm_we/dm_addr/   DM load/store request, held until dm_ack
//   dm_wdata
//   dm_ack/dm_rdata         one-cycle completion pulse + load data
//   bus_err                 pulses with the ack of a timed-out access
//   mem_req/mem_we/         memory request, held until mem_ack
//   mem_addr/mem_wdata
//   mem_rdata/mem_ack       memory read data, valid with one-cycle mem_ack
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_STARVE = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_ack,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  bus_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    // Starve counter must hold 0..MAX_STARVE; keep at least one bit when MAX_STARVE is 0.
    localparam int unsigned SW = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
    // Timeout counter counts BUSY cycles 0..TIMEOUT-1.
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [SW-1:0] STARVE_LIMIT = SW'(MAX_STARVE);
    localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    state_e                state_q,     state_d;
    owner_e                owner_q,     owner_d;
    logic [SW-1:0]         starve_q,    starve_d;
    logic [TW-1:0]         tmo_q,       tmo_d;
    logic                  mem_req_q,   mem_req_d;
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  if_ack_q,    if_ack_d;
    logic                  dm_ack_q,    dm_ack_d;
    logic [DATA_WIDTH-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q,  dm_rdata_d;
    logic                  bus_err_q,   bus_err_d;

    logic if_elig;
    logic dm_elig;
    logic grant_if;
    logic grant_dm;

    // A request whose ack is being shown this cycle is stale and not eligible.
    assign if_elig  = if_req && !if_ack_q;
    assign dm_elig  = dm_req && !dm_ack_q;

    // DM wins conflicts unless IF has already lost MAX_STARVE times in a row.
    assign grant_if = if_elig && (!dm_elig || (starve_q == STARVE_LIMIT));
    assign grant_dm = dm_elig && !grant_if;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        bus_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    owner_d     = OWN_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    tmo_d       = '0;
                    starve_d    = '0;
                    state_d     = BUSY;
                end else if (grant_dm) begin
                    owner_d     = OWN_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    tmo_d       = '0;
                    // Only a loss against a live IF request counts toward starvation.
                    if (if_elig && (starve_q != STARVE_LIMIT)) begin
                        starve_d = starve_q + SW'(1);
                    end
                    state_d     = BUSY;
                end
            end

            BUSY: begin
                // mem_ack takes priority over a timeout expiring in the same cycle.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (owner_q == OWN_DM) begin
                        dm_rdata_d = mem_rdata;
                        dm_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_ack_d   = 1'b1;
                    end
                    state_d = RESP;
                end else if (tmo_q == TMO_LAST) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    bus_err_d = 1'b1;
                    if (owner_q == OWN_DM) begin
                        dm_rdata_d = '0;
                        dm_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = '0;
                        if_ack_d   = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            starve_q    <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed stimulus for mem_port_arbiter. Expected requester responses and
//   expected memory transactions are queued when a test is issued; a monitor
//   checks each ack against the response queue and a memory model checks each
//   memory transaction against the memory queue and returns its data.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int WAIT_BUDGET = 300;

    logic          clk;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;
    logic          bus_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    mem_port_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_STARVE (4),
        .TIMEOUT    (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // lat = cycle of mem_req in which the model acks (0 = never);
    // len = expected mem_req high cycles (0 = not checked).
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            lat;
        logic [DW-1:0] rdata;
        int            len;
    } mem_exp_t;

    typedef struct {
        bit            is_dm;
        logic [DW-1:0] rdata;
        bit            chk_data;
        bit            err;
    } rsp_t;

    mem_exp_t mem_q[$];
    rsp_t     sb_q[$];

    int inject_req  = 0;
    int inject_seen = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic push_mem(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input int lat, input logic [DW-1:0] rdata, input int len);
        mem_exp_t e;
        e.we = we; e.addr = addr; e.wdata = wdata; e.lat = lat; e.rdata = rdata; e.len = len;
        mem_q.push_back(e);
    endtask

    task automatic push_rsp(input bit is_dm, input logic [DW-1:0] rdata, input bit chk_data, input bit err);
        rsp_t r;
        r.is_dm = is_dm; r.rdata = rdata; r.chk_data = chk_data; r.err = err;
        sb_q.push_back(r);
    endtask

    // Waits (bounded) for the requester's ack; returns at the negedge the ack is seen.
    task automatic wait_ack(input bit is_dm);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < WAIT_BUDGET) begin
            @(negedge clk);
            n++;
            seen = is_dm ? dm_ack : if_ack;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_ack_timeout: no ack within %0d cycles", is_dm ? "dm" : "if", WAIT_BUDGET);
        end
    endtask

    task automatic dm_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        dm_req   = 1'b1;
        dm_we    = we;
        dm_addr  = addr;
        dm_wdata = wdata;
        wait_ack(1'b1);
    endtask

    task automatic if_access(input logic [AW-1:0] addr);
        if_req  = 1'b1;
        if_addr = addr;
        wait_ack(1'b0);
    endtask

    // Memory model: checks each transaction at its first mem_req cycle and its length.
    initial begin : mem_model
        bit       in_flight;
        int       cnt;
        mem_exp_t cur;
        in_flight = 1'b0;
        cnt       = 0;
        cur.we = 1'b0; cur.addr = '0; cur.wdata = '0; cur.lat = 1; cur.rdata = '0; cur.len = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = '0;
            if (mem_req) begin
                if (!in_flight) begin
                    in_flight = 1'b1;
                    cnt       = 0;
                    if (mem_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mem_unexpected: mem_req with addr %0h, none expected", mem_addr);
                        cur.we = 1'b0; cur.addr = '0; cur.wdata = '0; cur.lat = 1; cur.rdata = '0; cur.len = 0;
                    end else begin
                        cur = mem_q.pop_front();
                        chk("mem_we", 64'(mem_we), 64'(cur.we));
                        chk("mem_addr", 64'(mem_addr), 64'(cur.addr));
                        if (cur.we) chk("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
                    end
                end
                cnt++;
                if (cur.lat != 0 && cnt == cur.lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = cur.rdata;
                end
            end else if (in_flight) begin
                in_flight = 1'b0;
                if (cur.len != 0) chk("mem_req_len", 64'(cnt), 64'(cur.len));
            end
            // Stray ack outside any transaction.
            if (inject_req != inject_seen) begin
                inject_seen = inject_req;
                mem_ack     = 1'b1;
                mem_rdata   = 32'hBAD0_BAD0;
            end
        end
    end

    // Monitor: every ack pops one expected response.
    initial begin : monitor
        rsp_t r;
        forever begin
            @(negedge clk);
            if (if_ack || dm_ack) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: if_ack=%0b dm_ack=%0b with none expected (t=%0t)",
                             if_ack, dm_ack, $time);
                end else begin
                    r = sb_q.pop_front();
                    chk("ack_port", 64'({if_ack, dm_ack}), r.is_dm ? 64'(2'b01) : 64'(2'b10));
                    if (r.chk_data) chk("rdata", r.is_dm ? 64'(dm_rdata) : 64'(if_rdata), 64'(r.rdata));
                    chk("bus_err", 64'(bus_err), 64'(r.err));
                end
            end else if (bus_err) begin
                checks++;
                errors++;
                $display("FAIL bus_err_alone: bus_err=1 without ack (t=%0t)", $time);
            end
        end
    end

    initial begin : watchdog
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int hi;
        reset    = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_acks", 64'({if_ack, dm_ack, bus_err}), 64'(0));
        chk("rst_rdata", 64'({if_rdata, dm_rdata}), 64'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: DM load alone, ack in 3rd mem_req cycle
        push_mem(1'b0, 16'h0040, '0, 3, 32'hDEAD_BEEF, 3);
        push_rsp(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        fork
            begin
                dm_access(1'b0, 16'h0040, 32'h0);
                dm_req = 1'b0;
            end
            begin
                @(negedge clk);
                chk("t1_mem_req_latency", 64'(mem_req), 64'(1));
            end
        join
        repeat (2) @(negedge clk);

        // 2: starvation - DM x4, then IF forced, then DM (starve cleared), then IF
        push_mem(1'b0, 16'h0020, '0, 2, 32'hD000_0001, 2);
        push_mem(1'b0, 16'h0024, '0, 2, 32'hD000_0002, 2);
        push_mem(1'b0, 16'h0028, '0, 2, 32'hD000_0003, 2);
        push_mem(1'b0, 16'h002C, '0, 2, 32'hD000_0004, 2);
        push_mem(1'b0, 16'h0100, '0, 2, 32'h1F00_0001, 2);
        push_mem(1'b0, 16'h0030, '0, 2, 32'hD000_0005, 2);
        push_mem(1'b0, 16'h0104, '0, 2, 32'h1F00_0002, 2);
        push_rsp(1'b1, 32'hD000_0001, 1'b1, 1'b0);
        push_rsp(1'b1, 32'hD000_0002, 1'b1, 1'b0);
        push_rsp(1'b1, 32'hD000_0003, 1'b1, 1'b0);
        push_rsp(1'b1, 32'hD000_0004, 1'b1, 1'b0);
        push_rsp(1'b0, 32'h1F00_0001, 1'b1, 1'b0);
        push_rsp(1'b1, 32'hD000_0005, 1'b1, 1'b0);
        push_rsp(1'b0, 32'h1F00_0002, 1'b1, 1'b0);
        fork
            begin
                dm_access(1'b0, 16'h0020, 32'h0);
                dm_access(1'b0, 16'h0024, 32'h0);
                dm_access(1'b0, 16'h0028, 32'h0);
                dm_access(1'b0, 16'h002C, 32'h0);
                dm_access(1'b0, 16'h0030, 32'h0);
                dm_req = 1'b0;
            end
            begin
                if_access(16'h0100);
                if_access(16'h0104);
                if_req = 1'b0;
            end
        join
        repeat (2) @(negedge clk);

        // 3: DM store with IF held - store first, then IF once
        push_mem(1'b1, 16'h0010, 32'h1234_5678, 2, 32'h0, 2);
        push_mem(1'b0, 16'h0200, '0, 1, 32'h0000_0013, 1);
        push_rsp(1'b1, 32'h0, 1'b0, 1'b0);
        push_rsp(1'b0, 32'h0000_0013, 1'b1, 1'b0);
        fork
            begin
                dm_access(1'b1, 16'h0010, 32'h1234_5678);
                dm_req = 1'b0;
            end
            begin
                if_access(16'h0200);
                if_req = 1'b0;
            end
        join
        repeat (2) @(negedge clk);

        // 4: memory never acks - abort after 64 cycles with bus_err and zero data
        push_mem(1'b0, 16'h0080, '0, 0, 32'h0, 64);
        push_rsp(1'b1, 32'h0, 1'b1, 1'b1);
        dm_access(1'b0, 16'h0080, 32'h0);
        dm_req = 1'b0;
        repeat (2) @(negedge clk);

        // 5: reset in BUSY, stray mem_ack after release
        push_mem(1'b0, 16'h00C0, '0, 0, 32'h0, 0);
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 16'h00C0;
        repeat (3) @(negedge clk);
        chk("t5_busy", 64'(mem_req), 64'(1));
        reset  = 1'b1;
        dm_req = 1'b0;
        #1;
        chk("t5_rst_mem", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'(0));
        chk("t5_rst_acks", 64'({if_ack, dm_ack, bus_err}), 64'(0));
        chk("t5_rst_if_rdata", 64'(if_rdata), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        inject_req = inject_req + 1;
        hi = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_req) hi++;
        end
        chk("t5_stays_idle", 64'(hi), 64'(0));

        // 6: IF req held through ack cycle, new request granted the cycle after
        push_mem(1'b0, 16'h0300, '0, 1, 32'h1111_1111, 1);
        push_mem(1'b0, 16'h0304, '0, 1, 32'h2222_2222, 1);
        push_rsp(1'b0, 32'h1111_1111, 1'b1, 1'b0);
        push_rsp(1'b0, 32'h2222_2222, 1'b1, 1'b0);
        if_access(16'h0300);
        fork
            begin
                if_access(16'h0304);
                if_req = 1'b0;
            end
            begin
                @(negedge clk);
                chk("t6_no_grant_in_ack", 64'(mem_req), 64'(0));
                @(negedge clk);
                chk("t6_grant_next", 64'(mem_req), 64'(1));
            end
        join
        repeat (4) @(negedge clk);

        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        chk("mem_q_empty", 64'(mem_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
